systolic_array_nxm: RTL

- Parametrised ROWS x COLS weight-stationary systolic array of fixed-point MAC PEs; successor to the fixed 2x2 `systolic` block.
- Activations enter on the left edge, pre-skewed by the caller, and move right. Weights load from the top into per-PE shadow registers.
- A diagonal switch wavefront copies shadow weights into the active weights. This double-buffering lets the next tile load while the current tile computes.
- Partial sums move down the array. Results leave at the bottom, gated by a runtime active-column count from the unified buffer.

---
 rtl/systolic_array_nxm.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/systolic_array_nxm.sv
// systolic_array_nxm: ROWS x COLS weight-stationary systolic array of
// fixed-point MAC processing elements.
// Activations enter on the left edge and move right. Weights shift down into
// per-PE shadow registers, and a diagonal switch wavefront copies them into
// the active weights. Partial sums move down and leave at the bottom, gated
// by a runtime active-column count.
// Optional build macro SYSTOLIC_SAT_EN: saturate the shifted product and the
// accumulate to the signed DATA_W range instead of truncating and wrapping.
module systolic_array_nxm #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              ub_rd_col_size_in,
  input  logic                     ub_rd_col_size_valid_in,
  input  logic [ROWS*DATA_W-1:0]   sys_data_in,
  input  logic [ROWS-1:0]          sys_start,
  input  logic [COLS*DATA_W-1:0]   sys_weight_in,
  input  logic [COLS-1:0]          sys_accept_w,
  input  logic                     sys_switch_in,
  output logic [COLS*DATA_W-1:0]   sys_data_out,
  output logic [COLS-1:0]          sys_valid_out
);

  localparam int PW = 2 * DATA_W;

`ifdef SYSTOLIC_SAT_EN
  localparam logic signed [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Full-precision product, rescaled to the word format, clamped to range.
  function automatic logic signed [DATA_W-1:0] mul_shift(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] w
  );
    logic signed [PW-1:0] prod;
    prod = PW'(a) * PW'(w);
    prod = prod >>> FRAC_W;
    if (prod > PW'(DMAX)) return DMAX;
    if (prod < PW'(DMIN)) return DMIN;
    return prod[DATA_W-1:0];
  endfunction

  // Accumulate with one guard bit, clamped to range.
  function automatic logic signed [DATA_W-1:0] acc_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W:0] s;
    s = (DATA_W+1)'(a) + (DATA_W+1)'(b);
    if (s > (DATA_W+1)'(DMAX)) return DMAX;
    if (s < (DATA_W+1)'(DMIN)) return DMIN;
    return s[DATA_W-1:0];
  endfunction
`else
  // Full-precision product; taking DATA_W bits above the fraction is the
  // arithmetic shift followed by truncation.
  function automatic logic signed [DATA_W-1:0] mul_shift(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] w
  );
    logic signed [PW-1:0] prod;
    prod = PW'(a) * PW'(w);
    return prod[FRAC_W +: DATA_W];
  endfunction

  // Two's-complement accumulate, wrapping on overflow.
  function automatic logic signed [DATA_W-1:0] acc_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return a + b;
  endfunction
`endif

  // PE state, indexed [row][column]
  logic signed [DATA_W-1:0] act_q    [ROWS][COLS];
  logic signed [DATA_W-1:0] act_d    [ROWS][COLS];
  logic                     vld_q    [ROWS][COLS];
  logic                     vld_d    [ROWS][COLS];
  logic signed [DATA_W-1:0] shadow_q [ROWS][COLS];
  logic signed [DATA_W-1:0] shadow_d [ROWS][COLS];
  logic signed [DATA_W-1:0] active_q [ROWS][COLS];
  logic signed [DATA_W-1:0] active_d [ROWS][COLS];
  logic signed [DATA_W-1:0] psum_q   [ROWS][COLS];
  logic signed [DATA_W-1:0] psum_d   [ROWS][COLS];
  logic                     sw_q     [ROWS][COLS];
  logic                     sw_d     [ROWS][COLS];
  logic [15:0]              col_size_q;
  logic [15:0]              col_size_d;

  // Next state of every PE from its left/upper neighbours and the array edges.
  always_comb begin
    logic signed [DATA_W-1:0] a_in;
    logic signed [DATA_W-1:0] p_in;
    logic signed [DATA_W-1:0] s_in;
    logic                     v_in;
    logic                     w_in;
    int                       cm1;
    int                       rm1;
    a_in = '0;
    p_in = '0;
    s_in = '0;
    v_in = 1'b0;
    w_in = 1'b0;
    cm1  = 0;
    rm1  = 0;
    act_d    = act_q;
    vld_d    = vld_q;
    shadow_d = shadow_q;
    active_d = active_q;
    psum_d   = psum_q;
    sw_d     = sw_q;

    // Requests larger than the array are clamped to the array width.
    col_size_d = col_size_q;
    if (ub_rd_col_size_valid_in) begin
      col_size_d = (ub_rd_col_size_in > 16'(COLS)) ? 16'(COLS) : ub_rd_col_size_in;
    end

    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        // Neighbour indices kept in range even where the edge branch is taken.
        cm1 = (c > 0) ? c - 1 : 0;
        rm1 = (r > 0) ? r - 1 : 0;

        if (c == 0) begin
          a_in = sys_data_in[r*DATA_W +: DATA_W];
          v_in = sys_start[r];
        end else begin
          a_in = act_q[r][cm1];
          v_in = vld_q[r][cm1];
        end

        if (r == 0) begin
          p_in = '0;
          s_in = sys_weight_in[c*DATA_W +: DATA_W];
        end else begin
          p_in = psum_q[rm1][c];
          s_in = shadow_q[rm1][c];
        end

        // Switch token walks down column 0, then right along every row,
        // so PE(r,c) sees it r+c edges after injection.
        if (r == 0 && c == 0) begin
          w_in = sys_switch_in;
        end else if (c > 0) begin
          w_in = sw_q[r][cm1];
        end else begin
          w_in = sw_q[rm1][0];
        end

        act_d[r][c] = a_in;
        vld_d[r][c] = v_in;
        sw_d[r][c]  = w_in;

        if (sys_accept_w[c]) begin
          shadow_d[r][c] = s_in;
        end

        // Reads the pre-shift shadow, so a same-edge load does not leak in.
        if (w_in) begin
          active_d[r][c] = shadow_q[r][c];
        end

        // MAC uses the weight active before this edge's switch.
        psum_d[r][c] = v_in ? acc_add(mul_shift(a_in, active_q[r][c]), p_in) : '0;
      end
    end
  end

  // Register stage: all PE state advances one step per clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_size_q <= 16'(COLS);
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          act_q[r][c]    <= '0;
          vld_q[r][c]    <= 1'b0;
          shadow_q[r][c] <= '0;
          active_q[r][c] <= '0;
          psum_q[r][c]   <= '0;
          sw_q[r][c]     <= 1'b0;
        end
      end
    end else begin
      col_size_q <= col_size_d;
      act_q      <= act_d;
      vld_q      <= vld_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      psum_q     <= psum_d;
      sw_q       <= sw_d;
    end
  end

  // Bottom-row results, masked to the active column count.
  always_comb begin
    sys_data_out  = '0;
    sys_valid_out = '0;
    for (int c = 0; c < COLS; c++) begin
      if (vld_q[ROWS-1][c] && (16'(c) < col_size_q)) begin
        sys_valid_out[c]                 = 1'b1;
        sys_data_out[c*DATA_W +: DATA_W] = psum_q[ROWS-1][c];
      end
    end
  end

endmodule
